// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end. Issues one outstanding request
// at a time to instruction memory and buffers returned words in a 2-entry
// FIFO that feeds decode. A taken redirect from execute flushes the buffer.
// A request that is still in flight when the redirect arrives is allowed to
// complete, and its data is then dropped.
module fetch_ctrl #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic             StallD,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic             ValidD,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Next sequential fetch address; the adder wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(4);
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WIDTH-1:0] pc_align(input logic [WIDTH-1:0] pc);
    return {pc[WIDTH-1:2], 2'b00};
  endfunction

  // Fetch stage (p0): FSM, fetch PC, outstanding request.
  logic [1:0]       state_p0, state_d;
  logic [WIDTH-1:0] fpc_p0, fpc_d;
  logic [WIDTH-1:0] addr_p0, addr_d;
  logic             req_p0;

  // Buffer stage (p1): 2-entry FIFO of {instr, pc}.
  logic [WIDTH-1:0] instr_p1 [2];
  logic [WIDTH-1:0] pc_p1    [2];
  logic             rd_ptr_p1, wr_ptr_p1;
  logic [1:0]       count_p1;
  logic             vld_p1;

  logic             pop;
  logic             push;
  logic [1:0]       count_after_pop;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] target;

  // A redirect overrides any push or pop in the same cycle.
  always_comb begin
    pop             = vld_p1 & ~StallD & ~PCSrcE;
    push            = (state_p0 == ST_WAIT) & imem_ack & ~PCSrcE;
    count_after_pop = count_p1 - {1'b0, pop};
    count_next      = count_after_pop + {1'b0, push};
    target          = pc_align(PCTargetE);
  end

  // Next-state logic. A request is only issued when a slot is guaranteed
  // free for its data, so the FIFO can never be pushed while full.
  always_comb begin
    state_d = state_p0;
    fpc_d   = fpc_p0;
    addr_d  = addr_p0;
    case (state_p0)
      ST_IDLE: begin
        if (PCSrcE) begin
          state_d = ST_WAIT;
          fpc_d   = target;
          addr_d  = target;
        end else if (count_after_pop < 2'd2) begin
          state_d = ST_WAIT;
          addr_d  = fpc_p0;
        end
      end
      ST_WAIT: begin
        if (PCSrcE) begin
          fpc_d = target;
          if (imem_ack) begin
            addr_d = target;
          end else begin
            // Stale request stays on the bus until memory answers it.
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          fpc_d = pc_inc(addr_p0);
          if (count_next < 2'd2) begin
            addr_d = pc_inc(addr_p0);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (PCSrcE) begin
          fpc_d = target;
          if (imem_ack) begin
            state_d = ST_WAIT;
            addr_d  = target;
          end
        end else if (imem_ack) begin
          state_d = ST_WAIT;
          addr_d  = fpc_p0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch stage registers; imem_req is its own flop so it cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= ST_IDLE;
      fpc_p0   <= RESET_PC;
      addr_p0  <= RESET_PC;
      req_p0   <= 1'b0;
    end else begin
      state_p0 <= state_d;
      fpc_p0   <= fpc_d;
      addr_p0  <= addr_d;
      req_p0   <= (state_d != ST_IDLE);
    end
  end

  // Buffer stage control: occupancy, pointers and registered valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_p1 <= 1'b0;
      wr_ptr_p1 <= 1'b0;
      count_p1  <= 2'd0;
      vld_p1    <= 1'b0;
    end else if (PCSrcE) begin
      rd_ptr_p1 <= wr_ptr_p1;
      count_p1  <= 2'd0;
      vld_p1    <= 1'b0;
    end else begin
      if (push) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop)  rd_ptr_p1 <= ~rd_ptr_p1;
      count_p1 <= count_next;
      vld_p1   <= (count_next != 2'd0);
    end
  end

  // Buffer storage; reset so the decode outputs start at defined values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        instr_p1[i] <= '0;
        pc_p1[i]    <= RESET_PC;
      end
    end else if (push) begin
      instr_p1[wr_ptr_p1] <= imem_rdata;
      pc_p1[wr_ptr_p1]    <= addr_p0;
    end
  end

  assign imem_req  = req_p0;
  assign imem_addr = addr_p0;
  assign ValidD    = vld_p1;
  assign InstrD    = instr_p1[rd_ptr_p1];
  assign PCD       = pc_p1[rd_ptr_p1];
  assign PCPlus4D  = pc_inc(pc_p1[rd_ptr_p1]);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 SHALL have port PCSrcE  input  1  redirect request from execute (branch/jump taken).
REQ-006 SHALL have port PCTargetE  input  WIDTH  redirect target, sampled when PCSrcE=1.
REQ-007 SHALL have port StallD  input  1  decode cannot accept an instruction this cycle.
REQ-008 SHALL have port imem_ack  input  1  instruction memory completes the outstanding request this cycle.
REQ-009 SHALL have port imem_rdata  input  WIDTH  instruction word, valid only when imem_ack=1.
REQ-010 SHALL have port imem_req  output  1  request outstanding to instruction memory.
REQ-011 SHALL have port imem_addr  output  WIDTH  address of outstanding request.
REQ-012 SHALL have port ValidD  output  1  InstrD/PCD/PCPlus4D hold a valid instruction.
REQ-013 SHALL have port InstrD  output  WIDTH  instruction at buffer head.
REQ-014 SHALL have port PCD  output  WIDTH  PC of instruction at buffer head.
REQ-015 SHALL have port PCPlus4D  output  WIDTH  PCD+4, modulo 2^WIDTH.

Function
REQ-016 SHALL hold a fetch PC register (fpc), a 2-entry FIFO of {instr, pc} and a state machine with states IDLE, WAIT, DISCARD.
REQ-017 SHALL drive imem_req=1 exactly in WAIT and DISCARD, with imem_addr stable from request start until the imem_ack cycle.
REQ-018 SHALL keep at most one request outstanding; imem_ack while imem_req=0 is ignored.
REQ-019 IDLE->WAIT (imem_addr<=fpc) when FIFO occupancy after this cycle's pop is below 2 and no redirect; else stay IDLE.
REQ-020 WAIT with imem_ack, no redirect: push {imem_rdata, imem_addr}, fpc<=imem_addr+4; stay WAIT with imem_addr<=imem_addr+4 if post-push/pop occupancy <2, else go IDLE.
REQ-021 Pop SHALL occur when ValidD=1 and StallD=0; push and pop in the same cycle SHALL both take effect; ValidD=(occupancy>0).
REQ-022 Full FIFO SHALL never be pushed: REQ-019/020 guarantee a free slot per outstanding request.
REQ-023 PCSrcE=1 SHALL flush the FIFO (ValidD=0 next cycle), set fpc<=PCTargetE with bits [1:0] forced to 0, and override any same-cycle push or pop.
REQ-024 Redirect in IDLE, or in WAIT coinciding with imem_ack: ack data dropped; next state WAIT with imem_addr<=aligned PCTargetE.
REQ-025 Redirect in WAIT without imem_ack: go DISCARD, keep the stale request (imem_req=1, imem_addr unchanged) until ack.
REQ-026 DISCARD with imem_ack: data dropped, next state WAIT with imem_addr<=fpc; redirect in DISCARD updates fpc, state unchanged (or WAIT at new target if ack same cycle).
REQ-027 PC increments SHALL wrap modulo 2^WIDTH (32'hFFFF_FFFC+4=0).
REQ-028 With imem_ack every cycle and StallD=0, throughput SHALL be one instruction per cycle; request-to-ValidD latency SHALL be 1 cycle after the ack cycle.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, FIFO empty, fpc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ValidD=0, InstrD=0, PCD=RESET_PC, PCPlus4D=RESET_PC+4.
REQ-030 Reset asserted mid-request SHALL abandon the request; first request after release SHALL be RESET_PC, issued in the first cycle after rst deasserts.
REQ-031 Reset deassertion SHALL be honoured on a clock edge only; no output glitch other than the asynchronous reset assertion.

Verification
REQ-032 Reset release, imem_ack=1 always, StallD=0 -> imem_addr 0,4,8,12 on consecutive cycles; ValidD=1 with PCD=0 one cycle after first ack, then 4,8,...
REQ-033 StallD=1 for 4 cycles from reset, ack=1 always -> exactly 2 instrs (PC 0,4) buffered, imem_req=0 thereafter; StallD=0 -> PCD 0,4 pop, fetch resumes at 8.
REQ-034 Request to 8 pending, ack delayed 3 cycles, PCSrcE=1 PCTargetE=0x100 in cycle 1 -> DISCARD, addr 8 held until ack, data dropped, next request 0x100, ValidD=0 until 0x100 returns.
REQ-035 PCSrcE=1 with PCTargetE=0x203 coinciding with imem_ack -> ack data not pushed, FIFO flushed, next imem_addr=0x200.
REQ-036 fpc=32'hFFFF_FFFC, ack=1 -> PCD=FFFF_FFFC, PCPlus4D=0, next imem_addr=0.
REQ-037 rst=0 asserted mid-WAIT with FIFO 2 entries -> ValidD=0, imem_req=0 immediately (no clock); after release, imem_addr=RESET_PC.
